// File: rtl/tis_exec_node.sv
// -----------------------------------------------------------------------------
// tis_exec_node
//   Single TIS-100 style execution node. Fetches an 18-bit instruction from the
//   program source at the registered program counter, decodes it and executes
//   it against an 8-bit signed ACC / BAK register pair. Data moves to and from
//   the four neighbours over valid/ready handshaked ports.
//
//   Instruction layout (index 0 = MSB): op=[0:3] src=[4:6] dst=[7:9] imm=[10:17]
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   instr      [0:17]  in    instruction at addr_instr, combinational fetch
//   addr_instr [0:7]   out   registered program counter
//   in0..in3   [0:7]   in    input port data
//   in_valid   [0:3]   in    bit k: ink holds data
//   in_ready   [0:3]   out   bit k: node consumes ink this cycle (combinational)
//   out0..out3 [0:7]   out   registered output port data
//   out_valid  [0:3]   out   bit k: outk holds data (registered)
//   out_ready  [0:3]   in    bit k: neighbour accepts outk
//   stall              out   current instruction is blocked on a port
// -----------------------------------------------------------------------------
module tis_exec_node #(
  parameter int unsigned PROG_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:17] instr,
  output logic [0:7]  addr_instr,
  input  logic [0:7]  in0,
  input  logic [0:7]  in1,
  input  logic [0:7]  in2,
  input  logic [0:7]  in3,
  input  logic [0:3]  in_valid,
  output logic [0:3]  in_ready,
  output logic [0:7]  out0,
  output logic [0:7]  out1,
  output logic [0:7]  out2,
  output logic [0:7]  out3,
  output logic [0:3]  out_valid,
  input  logic [0:3]  out_ready,
  output logic        stall
);

  typedef enum logic {
    ST_EXEC,
    ST_WAIT_OUT
  } state_t;

  typedef enum logic [3:0] {
    OP_MOV = 4'h0,
    OP_SWP = 4'h1,
    OP_SUB = 4'h2,
    OP_ADD = 4'h3,
    OP_NEG = 4'h4,
    OP_SAV = 4'h5,
    OP_JMP = 4'h6,
    OP_JEZ = 4'h7,
    OP_JNZ = 4'h8,
    OP_JGZ = 4'h9,
    OP_JLZ = 4'hA,
    OP_NOP = 4'hF
  } op_t;

  localparam logic [7:0] LAST_PC  = 8'(PROG_LEN - 1);
  localparam logic [8:0] PROG_END = 9'(PROG_LEN);

  // ---------------------------------------------------------------------------
  // Registers and next-state signals
  // ---------------------------------------------------------------------------
  state_t     r_state, w_state_nxt;
  logic [1:0] r_wait_k, w_wait_k_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_acc, w_acc_nxt;
  logic [7:0] r_bak, w_bak_nxt;
  logic [7:0] r_out [4];
  logic [7:0] w_out_nxt [4];
  logic [0:3] r_ov, w_ov_nxt;

  // ---------------------------------------------------------------------------
  // Decode (internal vectors are descending so arithmetic reads naturally)
  // ---------------------------------------------------------------------------
  logic [17:0] w_instr;
  logic [3:0]  w_op;
  logic [2:0]  w_src;
  logic [2:0]  w_dst;
  logic [7:0]  w_imm;
  logic [7:0]  w_in [4];
  logic        w_uses_src;
  logic        w_src_port;
  logic [1:0]  w_src_k;
  logic        w_src_ok;
  logic [7:0]  w_operand;

  assign w_instr = instr;
  assign w_op    = w_instr[17:14];
  assign w_src   = w_instr[13:11];
  assign w_dst   = w_instr[10:8];
  assign w_imm   = w_instr[7:0];

  assign w_in[0] = in0;
  assign w_in[1] = in1;
  assign w_in[2] = in2;
  assign w_in[3] = in3;

  // Only MOV/ADD/SUB read their source; other opcodes never touch an input
  // port, whatever their src field happens to hold.
  assign w_uses_src = (w_op == OP_MOV) || (w_op == OP_ADD) || (w_op == OP_SUB);
  assign w_src_port = w_uses_src && !w_src[2];
  assign w_src_k    = w_src[1:0];
  assign w_src_ok   = !w_src_port || in_valid[w_src_k];

  always_comb begin
    w_operand = '0;
    case (w_src)
      3'b000, 3'b001, 3'b010, 3'b011: w_operand = w_in[w_src_k];
      3'b100:                         w_operand = r_acc;
      3'b110:                         w_operand = w_imm;
      default:                        w_operand = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] sat8(input logic signed [8:0] v);
    if (v > 9'sd127)
      return 8'h7F;
    else if (v < -9'sd128)
      return 8'h80;
    else
      return v[7:0];
  endfunction

  logic signed [8:0] w_sum;
  logic signed [8:0] w_diff;
  logic [7:0]        w_neg;

  assign w_sum  = $signed({r_acc[7], r_acc}) + $signed({w_operand[7], w_operand});
  assign w_diff = $signed({r_acc[7], r_acc}) - $signed({w_operand[7], w_operand});
  assign w_neg  = (r_acc == 8'h80) ? 8'h7F : (8'h00 - r_acc);

  // ---------------------------------------------------------------------------
  // Program counter helpers
  // ---------------------------------------------------------------------------
  logic [7:0] w_pc_inc;
  logic [7:0] w_jmp_tgt;
  logic       w_acc_zero;
  logic       w_acc_neg;
  logic       w_take;

  assign w_pc_inc   = (r_pc == LAST_PC) ? '0 : r_pc + 8'd1;
  assign w_jmp_tgt  = ({1'b0, w_imm} < PROG_END) ? w_imm : '0;
  assign w_acc_zero = (r_acc == 8'h00);
  assign w_acc_neg  = r_acc[7];

  always_comb begin
    w_take = 1'b0;
    case (w_op)
      OP_JMP:  w_take = 1'b1;
      OP_JEZ:  w_take = w_acc_zero;
      OP_JNZ:  w_take = !w_acc_zero;
      OP_JGZ:  w_take = !w_acc_zero && !w_acc_neg;
      OP_JLZ:  w_take = w_acc_neg;
      default: w_take = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_k_nxt = r_wait_k;
    w_pc_nxt     = r_pc;
    w_acc_nxt    = r_acc;
    w_bak_nxt    = r_bak;
    w_out_nxt    = r_out;
    w_ov_nxt     = r_ov;
    in_ready     = '0;
    stall        = 1'b0;

    case (r_state)
      ST_EXEC: begin
        if (w_src_port)
          in_ready[w_src_k] = 1'b1;
        if (!w_src_ok) begin
          stall = 1'b1;
        end else begin
          w_pc_nxt = w_pc_inc;
          case (w_op)
            OP_MOV: begin
              if (!w_dst[2]) begin
                // Output is loaded now; PC waits for the neighbour to accept.
                w_out_nxt[w_dst[1:0]] = w_operand;
                w_ov_nxt[w_dst[1:0]]  = 1'b1;
                w_wait_k_nxt          = w_dst[1:0];
                w_state_nxt           = ST_WAIT_OUT;
                w_pc_nxt              = r_pc;
              end else if (w_dst == 3'b100) begin
                w_acc_nxt = w_operand;
              end
            end
            OP_SWP: begin
              w_acc_nxt = r_bak;
              w_bak_nxt = r_acc;
            end
            OP_SUB: w_acc_nxt = sat8(w_diff);
            OP_ADD: w_acc_nxt = sat8(w_sum);
            OP_NEG: w_acc_nxt = w_neg;
            OP_SAV: w_bak_nxt = r_acc;
            OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ: begin
              if (w_take)
                w_pc_nxt = w_jmp_tgt;
            end
            default: ;
          endcase
        end
      end

      ST_WAIT_OUT: begin
        stall = 1'b1;
        if (r_ov[r_wait_k] && out_ready[r_wait_k]) begin
          w_ov_nxt[r_wait_k] = 1'b0;
          w_pc_nxt           = w_pc_inc;
          w_state_nxt        = ST_EXEC;
        end
      end

      default: w_state_nxt = ST_EXEC;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_EXEC;
      r_wait_k <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wait_k <= w_wait_k_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_acc <= '0;
      r_bak <= '0;
      r_ov  <= '0;
      for (int unsigned i = 0; i < 4; i++)
        r_out[i] <= '0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_acc <= w_acc_nxt;
      r_bak <= w_bak_nxt;
      r_ov  <= w_ov_nxt;
      for (int unsigned i = 0; i < 4; i++)
        r_out[i] <= w_out_nxt[i];
    end
  end

  assign addr_instr = r_pc;
  assign out0       = r_out[0];
  assign out1       = r_out[1];
  assign out2       = r_out[2];
  assign out3       = r_out[3];
  assign out_valid  = r_ov;

endmodule
